// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3 bus: on-chip RAM plus one I/O word,
// a fixed-latency read pipeline, and a RAM clearing sequence after reset.
//
// state | meaning
// CLEAR | writing zero to RAM[clr_cnt]; bus requests ignored
// READY | RAM cleared, requests serviced, init_done high
module slc3_mem_responder #(
    parameter int          ADDR_BITS    = 10,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] IO_ADDR      = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_mem_ena,
    input  logic        mem_wr_ena,
    input  logic [15:0] sw_i,
    output logic [15:0] mem_rdata,
    output logic        mem_rdata_valid,
    output logic [15:0] hex_o,
    output logic        init_done
);

    localparam int                 DEPTH    = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] CLR_LAST = (ADDR_BITS + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_BITS:0]      clr_cnt;
    logic [15:0]             ram [DEPTH];
    logic [15:0]             pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld;

    logic                 is_io;
    logic                 is_ram;
    logic                 wr_req;
    logic                 rd_req;
    logic [ADDR_BITS-1:0] ram_idx;

    assign ram_idx = mem_addr[ADDR_BITS-1:0];
    assign is_io   = (mem_addr == IO_ADDR);
    assign is_ram  = !is_io && ((mem_addr >> ADDR_BITS) == 16'd0);
    assign wr_req  = (state == READY) && mem_mem_ena && mem_wr_ena;
    assign rd_req  = (state == READY) && mem_mem_ena && !mem_wr_ena;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clr_cnt == CLR_LAST) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // RAM has no reset of its own; the CLEAR pass is what zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                ram[clr_cnt[ADDR_BITS-1:0]] <= 16'h0000;
            end else if (wr_req && is_ram) begin
                ram[ram_idx] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_o <= 16'h0000;
        end else if (wr_req && is_io) begin
            hex_o <= mem_wdata;
        end
    end

    // Stage 0 captures the read source at the request edge; each later stage
    // only loads when its predecessor holds a read, so the last stage (the
    // bus output) keeps its value between completions.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data[k] <= 16'h0000;
            end
        end else begin
            pipe_vld[0] <= rd_req;
            if (rd_req) begin
                if (is_io) begin
                    pipe_data[0] <= sw_i;
                end else if (is_ram) begin
                    pipe_data[0] <= ram[ram_idx];
                end else begin
                    pipe_data[0] <= 16'h0000;
                end
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign mem_rdata       = pipe_data[READ_LATENCY-1];
    assign mem_rdata_valid = pipe_vld[READ_LATENCY-1];
    assign init_done       = (state == READY);

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder (ADDR_BITS=10, READ_LATENCY=2).
module tb_slc3_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_mem_ena;
    logic        mem_wr_ena;
    logic [15:0] sw_i;
    logic [15:0] mem_rdata;
    logic        mem_rdata_valid;
    logic [15:0] hex_o;
    logic        init_done;

    int n_checks = 0;
    int n_fails  = 0;

    slc3_mem_responder #(
        .ADDR_BITS   (10),
        .READ_LATENCY(2),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_mem_ena    (mem_mem_ena),
        .mem_wr_ena     (mem_wr_ena),
        .sw_i           (sw_i),
        .mem_rdata      (mem_rdata),
        .mem_rdata_valid(mem_rdata_valid),
        .hex_o          (hex_o),
        .init_done      (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        mem_addr    = addr;
        mem_wdata   = data;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = 1'b1;
        tick();
        mem_mem_ena = 1'b0;
        mem_wr_ena  = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        mem_addr    = addr;
        mem_mem_ena = 1'b1;
        mem_wr_ena  = 1'b0;
        tick();
        mem_mem_ena = 1'b0;
        chk({tag, "_early"}, 32'(mem_rdata_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(mem_rdata_valid), 32'd1);
        chk({tag, "_data"}, 32'(mem_rdata), 32'(exp));
        tick();
        chk({tag, "_pulse_end"}, 32'(mem_rdata_valid), 32'd0);
    endtask

    // Counts edges until init_done rises; optionally fires bus requests
    // that must be ignored while the RAM is being cleared.
    task automatic wait_init(input bit stim, output int cycles, output int pulses);
        cycles = 0;
        pulses = 0;
        while (!init_done && cycles < 2000) begin
            mem_mem_ena = 1'b0;
            mem_wr_ena  = 1'b0;
            if (stim && cycles == 5) begin
                mem_addr = 16'hFFFF; mem_wdata = 16'hFFFF;
                mem_mem_ena = 1'b1;  mem_wr_ena = 1'b1;
            end else if (stim && (cycles == 6 || cycles == 7 || cycles == 1022)) begin
                mem_addr = 16'h0000; mem_mem_ena = 1'b1;
            end else if (stim && cycles == 1000) begin
                mem_addr = 16'hFFFF; mem_wdata = 16'h1111;
                mem_mem_ena = 1'b1;  mem_wr_ena = 1'b1;
            end
            tick();
            cycles++;
            if (mem_rdata_valid) pulses++;
        end
        mem_mem_ena = 1'b0;
        mem_wr_ena  = 1'b0;
    endtask

    logic [15:0] bb_exp [4];

    initial begin
        int cycles;
        int pulses;

        reset = 1'b1; mem_addr = '0; mem_wdata = '0;
        mem_mem_ena = 1'b0; mem_wr_ena = 1'b0; sw_i = 16'h0000;
        tick(); tick();
        chk("rst_rdata", 32'(mem_rdata), 32'd0);
        chk("rst_valid", 32'(mem_rdata_valid), 32'd0);
        chk("rst_hex", 32'(hex_o), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        reset = 1'b0;
        wait_init(1'b1, cycles, pulses);
        chk("init_cycles", 32'(cycles), 32'd1024);
        chk("clear_no_pulses", 32'(pulses), 32'd0);
        chk("clear_hex_untouched", 32'(hex_o), 32'd0);

        do_read(16'h0000, 16'h0000, "clr_0000");
        do_read(16'h01FF, 16'h0000, "clr_01ff");
        do_read(16'h03FF, 16'h0000, "clr_03ff");

        do_write(16'h0010, 16'h1234);
        do_read(16'h0010, 16'h1234, "raw_0010");

        do_write(16'hFFFF, 16'hBEEF);
        chk("hex_write", 32'(hex_o), 32'h0000BEEF);
        chk("write_keeps_rdata", 32'(mem_rdata), 32'h00001234);
        sw_i = 16'h00A5;
        do_read(16'hFFFF, 16'h00A5, "io_read");
        sw_i = 16'h0000;
        chk("hex_hold", 32'(hex_o), 32'h0000BEEF);

        do_write(16'h0000, 16'h0ABC);
        do_write(16'h0400, 16'h5555);
        do_read(16'h0400, 16'h0000, "unmapped");
        do_read(16'h0000, 16'h0ABC, "alias_check");

        bb_exp[0] = 16'h0011; bb_exp[1] = 16'h0022;
        bb_exp[2] = 16'h0033; bb_exp[3] = 16'h0044;
        for (int i = 0; i < 4; i++) do_write(16'(i + 1), bb_exp[i]);
        for (int i = 0; i < 4; i++) begin
            mem_addr = 16'(i + 1); mem_mem_ena = 1'b1; mem_wr_ena = 1'b0;
            tick();
            if (i == 0) begin
                chk("bb_early", 32'(mem_rdata_valid), 32'd0);
            end else begin
                chk($sformatf("bb%0d_valid", i - 1), 32'(mem_rdata_valid), 32'd1);
                chk($sformatf("bb%0d_data", i - 1), 32'(mem_rdata), 32'(bb_exp[i-1]));
            end
        end
        mem_mem_ena = 1'b0;
        tick();
        chk("bb3_valid", 32'(mem_rdata_valid), 32'd1);
        chk("bb3_data", 32'(mem_rdata), 32'h00000044);
        tick();
        chk("bb_pulse_end", 32'(mem_rdata_valid), 32'd0);
        tick();
        chk("rdata_hold", 32'(mem_rdata), 32'h00000044);

        do_write(16'h0020, 16'h9999);
        mem_addr = 16'h0020; mem_mem_ena = 1'b1; mem_wr_ena = 1'b0;
        tick();
        mem_addr = 16'h0001;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_mem_ena = 1'b0;
        chk("mid_rst_valid", 32'(mem_rdata_valid), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_hex", 32'(hex_o), 32'd0);
        wait_init(1'b0, cycles, pulses);
        chk("reinit_cycles", 32'(cycles), 32'd1024);
        chk("reinit_no_pulses", 32'(pulses), 32'd0);
        do_read(16'h0020, 16'h0000, "reclear_0020");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
